sysid_checker: RTL and testbench

- Boot-time controller for the 2-word system-ID slave (address 0 = system ID, address 1 = build timestamp).
- Acts as an Avalon-MM read master: sequences both reads, captures the values and compares them against expected constants.
- Reports pass/fail/timeout to the board-level status logic (LEDs, CPU hold-off).
- Re-runs on a start pulse.

---
 rtl/sysid_checker.sv | 145 ++++++++++++++
 tb/tb_sysid_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Boot-time checker for the 2-word system-ID slave: reads ID and build timestamp
// over Avalon-MM, compares them against expected constants and reports the result.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1398709486,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             auto_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             busy_d, done_d, id_ok_d, ts_ok_d, timeout_d;
  logic [31:0]      id_value_d, ts_value_d;

  // State and all registered outputs; auto_q requests one launch right after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      auto_q   <= AUTO_START;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state_q  <= state_d;
      auto_q   <= 1'b0;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      id_ok    <= id_ok_d;
      ts_ok    <= ts_ok_d;
      timeout  <= timeout_d;
      id_value <= id_value_d;
      ts_value <= ts_value_d;
    end
  end

  // Next-state, read strobe decode and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_ok_d    = id_ok;
    ts_ok_d    = ts_ok;
    timeout_d  = timeout;
    id_value_d = id_value;
    ts_value_d = ts_value;
    m_read     = 1'b0;
    m_address  = 1'b0;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (auto_q || start) begin
          cnt_d   = '0;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        m_read = 1'b1;
        if (!m_waitrequest) begin
          id_value_d = m_readdata;
          cnt_d      = '0;
          state_d    = RD_TS;
        end else if (cnt_inc >= TO_LIMIT) begin
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          cnt_d     = cnt_inc;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_TS: begin
        m_read    = 1'b1;
        m_address = 1'b1;
        if (!m_waitrequest) begin
          ts_value_d = m_readdata;
          cnt_d      = '0;
          state_d    = CHECK;
        end else if (cnt_inc >= TO_LIMIT) begin
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          cnt_d     = cnt_inc;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CHECK: begin
        id_ok_d   = (id_value == EXPECTED_ID);
        ts_ok_d   = (ts_value == EXPECTED_TS);
        timeout_d = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        if (start) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = RD_ID;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: auto-start instance with default timeout and a
// manual-start instance with a short timeout, driven by a vector table plus sequences.
module tb_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1398709486;
  localparam logic [31:0] TS_BAD  = 32'd1398709487;
  localparam logic [31:0] ID_B    = 32'h1234_5678;
  localparam int unsigned NVEC    = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, wait_a;
  logic [31:0] ts_word_a, data_a;
  logic        addr_a, rd_a, busy_a, done_a, idok_a, tsok_a, to_a;
  logic [31:0] idv_a, tsv_a;
  logic [6:0]  st_a;

  logic        rst_b, start_b, wait_b;
  logic [31:0] data_b;
  logic        addr_b, rd_b, busy_b, done_b, idok_b, tsok_b, to_b;
  logic [31:0] idv_b, tsv_b;
  logic [6:0]  st_b;

  // Zero-latency slave models: word 0 = ID, word 1 = timestamp
  assign data_a = addr_a ? ts_word_a : 32'd0;
  assign data_b = addr_b ? TS_GOOD : ID_B;
  assign st_a = {rd_a, addr_a, busy_a, done_a, idok_a, tsok_a, to_a};
  assign st_b = {rd_b, addr_b, busy_b, done_b, idok_b, tsok_b, to_b};

  sysid_checker dut_a (
    .clock(clk), .reset_n(rst_a), .start(start_a),
    .m_address(addr_a), .m_read(rd_a), .m_waitrequest(wait_a), .m_readdata(data_a),
    .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .timeout(to_a),
    .id_value(idv_a), .ts_value(tsv_a)
  );

  sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) dut_b (
    .clock(clk), .reset_n(rst_b), .start(start_b),
    .m_address(addr_b), .m_read(rd_b), .m_waitrequest(wait_b), .m_readdata(data_b),
    .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .timeout(to_b),
    .id_value(idv_b), .ts_value(tsv_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Status bit order: m_read, m_address, busy, done, id_ok, ts_ok, timeout
  typedef struct {
    logic        start;
    logic        stall;
    logic [31:0] ts;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic setv(input int idx, input logic s, input logic w, input logic [31:0] ts,
                      input logic [6:0] e);
    vecs[idx].start = s;
    vecs[idx].stall = w;
    vecs[idx].ts    = ts;
    vecs[idx].exp   = e;
  endtask

  initial begin
    // Auto-start, no stalls, matching words
    setv(0,  1'b0, 1'b0, TS_GOOD, 7'b1010000);
    setv(1,  1'b0, 1'b0, TS_GOOD, 7'b1110000);
    setv(2,  1'b0, 1'b0, TS_GOOD, 7'b0010000);
    setv(3,  1'b0, 1'b0, TS_GOOD, 7'b0001110);
    setv(4,  1'b0, 1'b0, TS_GOOD, 7'b0001110);
    // Restart from DONE with a wrong timestamp
    setv(5,  1'b1, 1'b0, TS_BAD,  7'b1010000);
    setv(6,  1'b0, 1'b0, TS_BAD,  7'b1110000);
    setv(7,  1'b0, 1'b0, TS_BAD,  7'b0010000);
    setv(8,  1'b0, 1'b0, TS_BAD,  7'b0001100);
    // Restart, start ignored while busy, 5 stall cycles in RD_TS
    setv(9,  1'b1, 1'b0, TS_GOOD, 7'b1010000);
    setv(10, 1'b1, 1'b0, TS_GOOD, 7'b1110000);
    setv(11, 1'b0, 1'b1, TS_GOOD, 7'b1110000);
    setv(12, 1'b1, 1'b1, TS_GOOD, 7'b1110000);
    setv(13, 1'b0, 1'b1, TS_GOOD, 7'b1110000);
    setv(14, 1'b0, 1'b1, TS_GOOD, 7'b1110000);
    setv(15, 1'b0, 1'b1, TS_GOOD, 7'b1110000);
    setv(16, 1'b0, 1'b0, TS_GOOD, 7'b0010000);
    setv(17, 1'b0, 1'b0, TS_GOOD, 7'b0001110);
    setv(18, 1'b0, 1'b0, TS_GOOD, 7'b0001110);

    rst_a = 1'b0; start_a = 1'b0; wait_a = 1'b0; ts_word_a = TS_GOOD;
    rst_b = 1'b0; start_b = 1'b0; wait_b = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_status_a", 32'(st_a), 32'd0);
    check("reset_id_value_a", idv_a, 32'd0);
    check("reset_ts_value_a", tsv_a, 32'd0);
    check("reset_status_b", 32'(st_b), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      start_a   = vecs[i].start;
      wait_a    = vecs[i].stall;
      ts_word_a = vecs[i].ts;
      @(negedge clk);
      check($sformatf("vec%0d_status", i), 32'(st_a), 32'(vecs[i].exp));
      if (i == 4 || i == 18) check($sformatf("vec%0d_ts_value", i), tsv_a, TS_GOOD);
      if (i == 8) check("vec8_ts_value", tsv_a, TS_BAD);
      if (i == 4) check("vec4_id_value", idv_a, 32'd0);
    end
    start_a = 1'b0;
    wait_a  = 1'b0;

    // AUTO_START=0 instance has stayed idle all along
    check("b_idle_no_autostart", 32'(st_b), 32'd0);

    // Timeout: waitrequest stuck high in RD_ID, limit 4
    start_b = 1'b1;
    wait_b  = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_rd_id_entered", 32'(st_b), 32'(7'b1010000));
    repeat (3) @(negedge clk);
    check("b_stall3_still_reading", 32'(st_b), 32'(7'b1010000));
    @(negedge clk);
    check("b_timeout_status", 32'(st_b), 32'(7'b0001001));
    check("b_timeout_id_kept", idv_b, 32'd0);
    wait_b = 1'b0;

    // Async reset during RD_TS, then no auto-start after release
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    check("b_rd_ts_status", 32'(st_b), 32'(7'b1110000));
    check("b_id_captured", idv_b, ID_B);
    #2 rst_b = 1'b0;
    #1;
    check("b_async_reset_status", 32'(st_b), 32'd0);
    check("b_async_reset_id_value", idv_b, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("b_idle_after_release", 32'(st_b), 32'd0);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("b_id_mismatch_result", 32'(st_b), 32'(7'b0001010));
    check("b_ts_value", tsv_b, TS_GOOD);

    // Async reset of the auto-start instance mid RD_TS, then relaunch on release
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check("a_rd_ts_before_reset", 32'(st_a), 32'(7'b1110000));
    #2 rst_a = 1'b0;
    #1;
    check("a_async_reset_status", 32'(st_a), 32'd0);
    check("a_async_reset_ts_value", tsv_a, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_autostart_after_release", 32'(st_a), 32'(7'b1010000));
    repeat (3) @(negedge clk);
    check("a_autostart_result", 32'(st_a), 32'(7'b0001110));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
